// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared types and constants for the multiply/divide-unit HI/LO controller.
package mdu_pkg;

  localparam int XLEN     = 32;
  localparam int RESULT_W = 2 * XLEN;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MTHI  = 4'd3,
    OP_MTLO  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_hilo_ctrl_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// (neg_i = sign bit; 0x80000000 maps to itself) and to re-apply the product sign.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  // Negate via invert-and-increment so the result wraps modulo 2^W.
  always_comb begin
    y_o = neg_i ? (~x_i + {{(W-1){1'b0}}, 1'b1}) : x_i;
  end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// Multiply-unit controller and HI/LO register file.
// Drives an external unsigned iterative multiplier over a valid/done handshake,
// fixes up the product sign and commits it to HI/LO.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built when MDU_MADD_EN
// is defined; otherwise those opcodes are accepted as NOPs.
//
//   state   | meaning
//   IDLE    | ready for a new request; MTHI/MTLO complete here
//   ISSUE   | one-cycle start pulse to the multiplier core
//   WAIT    | waiting for core done (first cycle ignored: done is stale-high)
//   CAPTURE | sign-fix product and write HI/LO unless aborted
module mdu_hilo_ctrl
  import mdu_pkg::*;
#(
  parameter int RESULT_W = mdu_pkg::RESULT_W,
  parameter int XLEN     = mdu_pkg::XLEN
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  input  logic [3:0]          req_op,
  input  logic [XLEN-1:0]     req_a,
  input  logic [XLEN-1:0]     req_b,
  output logic                req_ready,
  input  logic                flush,
  output logic                busy,
  output logic [XLEN-1:0]     hi,
  output logic [XLEN-1:0]     lo,
  output logic                mul_valid,
  output logic [XLEN-1:0]     mul_a,
  output logic [XLEN-1:0]     mul_b,
  input  logic                mul_done,
  input  logic [RESULT_W-1:0] mul_c
);

  mdu_state_t state_q, state_d;
  logic [XLEN-1:0] hi_q, lo_q, mul_a_q, mul_b_q;
  logic neg_q, abort_q, first_wait_q;
  logic accept, is_mul, is_signed;
  mdu_op_t op;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [RESULT_W-1:0] prod, commit_val;

  assign op        = mdu_op_t'(req_op);
  assign req_ready = (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);
  assign mul_valid = (state_q == S_ISSUE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

`ifdef MDU_MADD_EN
  logic is_acc, is_sub, acc_q, sub_q;
`endif

  // Opcode decode: which requests start the multiplier and with what signedness.
  always_comb begin
    is_mul    = 1'b0;
    is_signed = 1'b0;
`ifdef MDU_MADD_EN
    is_acc    = 1'b0;
    is_sub    = 1'b0;
`endif
    case (op)
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  mdu_sign_fix #(.W(XLEN)) u_fix_a (
    .x_i(req_a), .neg_i(is_signed && req_a[XLEN-1]), .y_o(mag_a)
  );
  mdu_sign_fix #(.W(XLEN)) u_fix_b (
    .x_i(req_b), .neg_i(is_signed && req_b[XLEN-1]), .y_o(mag_b)
  );
  mdu_sign_fix #(.W(RESULT_W)) u_fix_p (
    .x_i(mul_c), .neg_i(neg_q), .y_o(prod)
  );

`ifdef MDU_MADD_EN
  assign commit_val = !acc_q ? prod :
                      sub_q  ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);

  // Accumulate mode is latched alongside the operands at accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q <= 1'b0;
      sub_q <= 1'b0;
    end else if (accept && is_mul) begin
      acc_q <= is_acc;
      sub_q <= is_sub;
    end
  end
`else
  assign commit_val = prod;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept && is_mul) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (mul_done && !first_wait_q) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand latch, abort tracking and HI/LO writes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q         <= '0;
      lo_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      neg_q        <= 1'b0;
      abort_q      <= 1'b0;
      first_wait_q <= 1'b0;
    end else begin
      first_wait_q <= (state_q == S_ISSUE);
      if (accept) begin
        if (op == OP_MTHI) hi_q <= req_a;
        if (op == OP_MTLO) lo_q <= req_a;
        if (is_mul) begin
          mul_a_q <= mag_a;
          mul_b_q <= mag_b;
          neg_q   <= is_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
        end
      end
      if (state_q == S_CAPTURE) begin
        // A flush arriving in the capture cycle itself must also suppress the write.
        if (!abort_q && !flush) {hi_q, lo_q} <= commit_val;
        abort_q <= 1'b0;
      end else if (busy && flush) begin
        abort_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl: behavioural HI/LO model plus a
// multiplier-core model whose done level drops one cycle after the start pulse.
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, busy, mul_valid;
  logic [31:0] hi, lo, mul_a, mul_b;
  logic        mul_done = 1'b1;
  logic [63:0] mul_c = '0;

  int n_tests = 0, n_fail = 0, pulses = 0;

  mdu_hilo_ctrl dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo), .mul_valid(mul_valid), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Multiplier core model: product of whatever mul_a/mul_b hold when it finishes.
  int   core_lat = 6;
  int   core_cnt = 0;
  logic core_arm = 1'b0;
  always @(posedge clk) begin
    if (!resetn) begin
      mul_done <= 1'b1;
      core_cnt = 0;
      core_arm = 1'b0;
    end else if (core_arm) begin
      core_arm = 1'b0;
      mul_done <= 1'b0;
      core_cnt = core_lat;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        mul_done <= 1'b1;
        mul_c    <= {32'b0, mul_a} * {32'b0, mul_b};
      end
    end
    if (resetn && mul_valid) core_arm = 1'b1;
  end

  // Behavioural model. ph: 0 idle, 1 start-pulse cycle, 2 first wait cycle,
  // 3 later wait cycles, 4 commit cycle.
  int          ph = 0;
  logic        m_abort = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic [63:0] m_prod = '0;
  int          m_mode = 0;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? 32'(0 - x) : x;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      ph = 0; m_abort = 1'b0; m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
    end else begin
      case (ph)
        0: if (req_valid && !flush) begin
          logic sgn, mul;
          sgn = 1'b0; mul = 1'b0; m_mode = 0;
          case (req_op)
            4'd1: begin mul = 1; sgn = 1; end
            4'd2: mul = 1;
            4'd3: m_hi = req_a;
            4'd4: m_lo = req_a;
`ifdef MDU_MADD_EN
            4'd5: begin mul = 1; sgn = 1; m_mode = 1; end
            4'd6: begin mul = 1; m_mode = 1; end
            4'd7: begin mul = 1; sgn = 1; m_mode = 2; end
            4'd8: begin mul = 1; m_mode = 2; end
`endif
            default: ;
          endcase
          if (mul) begin
            m_prod = sgn ? 64'(longint'($signed(req_a)) * longint'($signed(req_b)))
                         : {32'b0, req_a} * {32'b0, req_b};
            m_a = mag(req_a, sgn);
            m_b = mag(req_b, sgn);
            ph = 1;
          end
        end
        1, 2, 3: begin
          if (flush) m_abort = 1'b1;
          if (ph == 3) begin if (mul_done) ph = 4; end
          else ph = ph + 1;
        end
        default: begin
          if (!m_abort && !flush) begin
            if (m_mode == 1)      {m_hi, m_lo} = {m_hi, m_lo} + m_prod;
            else if (m_mode == 2) {m_hi, m_lo} = {m_hi, m_lo} - m_prod;
            else                  {m_hi, m_lo} = m_prod;
          end
          m_abort = 1'b0;
          ph = 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (mul_valid) pulses++;
    chk("busy",      64'(busy),      64'(ph != 0));
    chk("req_ready", 64'(req_ready), 64'(ph == 0 && !flush));
    chk("mul_valid", 64'(mul_valid), 64'(ph == 1));
    chk("hi",        64'(hi),        64'(m_hi));
    chk("lo",        64'(lo),        64'(m_lo));
    chk("mul_a",     64'(mul_a),     64'(m_a));
    chk("mul_b",     64'(mul_b),     64'(m_b));
  end

  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic f);
    @(posedge clk); #1;
    req_valid = v; req_op = op; req_a = a; req_b = b; flush = f;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step(0, 4'd0, '0, '0, 0);
      if (!busy) break;
    end
    if (i == budget) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  initial begin
    int p0;
    repeat (3) step(0, 4'd0, '0, '0, 0);
    resetn = 1'b1;
    step(0, 4'd0, '0, '0, 0);
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_ready", 64'(req_ready), 64'h1);

    // MULT -3 * 5
    p0 = pulses;
    step(1, 4'd1, 32'hFFFFFFFD, 32'd5, 0);
    step(0, 4'd0, '0, '0, 0);
    chk("mult_busy", 64'(busy), 64'h1);
    wait_idle(100);
    chk("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    chk("mult_pulses", 64'(pulses - p0), 64'd1);

    step(1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    wait_idle(100);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    step(1, 4'd1, 32'h80000000, 32'h80000000, 0);
    wait_idle(100);
    chk("mult_min", {hi, lo}, 64'h40000000_00000000);

    // Back-to-back moves; a flushed MTHI must not land.
    step(1, 4'd3, 32'h12345678, '0, 0);
    step(1, 4'd4, 32'h9ABCDEF0, '0, 0);
    chk("mthi", 64'(hi), 64'h12345678);
    chk("mthi_ready", 64'(req_ready), 64'h1);
    step(1, 4'd3, 32'hDEADBEEF, '0, 1);
    chk("mtlo", 64'(lo), 64'h9ABCDEF0);
    step(0, 4'd0, '0, '0, 0);
    chk("flush_idle_hi", 64'(hi), 64'h12345678);

    // Flush in the 5th wait cycle of MULT 7x6.
    core_lat = 12;
    step(1, 4'd1, 32'd7, 32'd6, 0);
    step(0, 4'd0, '0, '0, 0);
    repeat (4) step(0, 4'd0, '0, '0, 0);
    step(0, 4'd0, '0, '0, 1);
    step(0, 4'd0, '0, '0, 0);
    chk("flush_still_busy", 64'(busy), 64'h1);
    wait_idle(100);
    chk("flush_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    step(1, 4'd2, 32'd2, 32'd3, 0);
    wait_idle(100);
    chk("after_flush", {hi, lo}, 64'd6);

    // Reset while waiting on the core.
    step(1, 4'd1, 32'd3, 32'd4, 0);
    repeat (3) step(0, 4'd0, '0, '0, 0);
    @(posedge clk); #1; resetn = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_valid", 64'(mul_valid), 64'h0);
    resetn = 1'b1;
    step(0, 4'd0, '0, '0, 0);

`ifdef MDU_MADD_EN
    core_lat = 4;
    step(1, 4'd4, 32'd5, '0, 0);
    step(1, 4'd3, 32'd0, '0, 0);
    step(1, 4'd5, 32'd2, 32'd3, 0);
    wait_idle(100);
    chk("madd", {hi, lo}, 64'h0000000B);
    step(1, 4'd8, 32'd1, 32'hC, 0);
    wait_idle(100);
    chk("msubu", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
`endif

    // Randomized traffic with corner-biased operands and occasional flush.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 << $urandom_range(0, 1) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      if (!busy) core_lat = $urandom_range(1, 10);
      step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 9)), a, b,
           $urandom_range(0, 19) == 0);
    end
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
